// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core req/gnt/rvalid port to single APB3 transfers
// One transfer in flight; an ACCESS phase that never sees pready ends with an error after TIMEOUT_CYCLES.
module apb_master_bridge #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   output logic                      gnt_o,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic                      we_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   output logic                      pwrite_o,
   output logic                      psel_o,
   output logic                      penable_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d, cnt_inc;
   logic [APB_ADDR_WIDTH-1:0]   paddr_d;
   logic [APB_DATA_WIDTH-1:0]   pwdata_d, rdata_d;
   logic                        pwrite_d, psel_d, penable_d, rvalid_d, err_d;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      paddr_d   = paddr_o;
      pwdata_d  = pwdata_o;
      pwrite_d  = pwrite_o;
      psel_d    = psel_o;
      penable_d = penable_o;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_o;
      err_d     = err_o;
      gnt_o     = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_o = req_i;
            if (req_i) begin
               paddr_d   = addr_i;
               pwdata_d  = wdata_i;
               pwrite_d  = we_i;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               cnt_d     = '0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               rdata_d   = pwrite_o ? '0 : prdata_i;
               err_d     = pslverr_i;
               rvalid_d  = 1'b1;
               state_d   = RESP;
            end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_LIMIT) begin
               // this is the last permitted waited ACCESS cycle: abort the hung slave
               psel_d    = 1'b0;
               penable_d = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b1;
               rvalid_d  = 1'b1;
               state_d   = RESP;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_d = cnt_inc;
            end
         end
         RESP: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         pwrite_o  <= 1'b0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         rvalid_o  <= 1'b0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         paddr_o   <= paddr_d;
         pwdata_o  <= pwdata_d;
         pwrite_o  <= pwrite_d;
         psel_o    <= psel_d;
         penable_o <= penable_d;
         rvalid_o  <= rvalid_d;
         rdata_o   <= rdata_d;
         err_o     <= err_d;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
// Driver pushes expectations at grant; APB slave model and monitor check independently.
module tb_apb_master_bridge;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_i, req_i, gnt_o, we_i, rvalid_o, err_o, pwrite_o, psel_o, penable_o;
   logic        pready_i, pslverr_i;
   logic [31:0] addr_i, wdata_i, rdata_o, paddr_o, pwdata_o, prdata_i;

   apb_master_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
      .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
      .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; int cyc;} apb_t;
   typedef struct {logic [31:0] rdata; logic err; int acc; int cyc;} rsp_t;
   typedef struct {int ws; logic [31:0] pd; logic se;} slv_t;

   apb_t apb_q[$];
   rsp_t rsp_q[$];
   slv_t slv_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_gnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a slave that would answer after ws wait states, unless the bridge gives up first.
   function automatic rsp_t model(input logic we, input int ws, input logic [31:0] pd, input logic se);
      rsp_t r;
      if (ws >= TO) begin
         r.rdata = 32'h0; r.err = 1'b1; r.acc = TO;
      end else begin
         r.rdata = we ? 32'h0 : pd; r.err = se; r.acc = ws + 1;
      end
      r.cyc = 0;
      return r;
   endfunction

   // APB slave model: pready after the programmed number of wait states, garbage otherwise.
   int   s_acc = 0;
   bit   s_act = 0;
   slv_t s_cur;
   always @(negedge clk) begin
      if (psel_o && !penable_o) begin
         if (slv_q.size() != 0) begin
            s_cur = slv_q.pop_front();
            s_act = 1;
         end
         s_acc = 0; pready_i = 1'b0;
      end else if (psel_o && penable_o && s_act) begin
         if (s_acc == s_cur.ws) begin
            pready_i = 1'b1; prdata_i = s_cur.pd; pslverr_i = s_cur.se;
         end else begin
            pready_i = 1'b0; prdata_i = 32'($urandom); pslverr_i = 1'($urandom);
         end
         s_acc++;
      end else begin
         s_act = 0; pready_i = 1'b0; prdata_i = 32'($urandom); pslverr_i = 1'b0;
      end
   end

   // Monitor
   logic        prev_psel = 1'b0, prev_rvalid = 1'b0;
   logic [31:0] cur_addr, cur_wdata;
   logic        cur_we;
   int          m_acc = 0;
   always @(negedge clk) begin
      if (!rst_i) begin
         if (gnt_o) chk("gnt_only_idle", {29'h0, psel_o, penable_o, rvalid_o}, 32'h0);
         if (psel_o && !penable_o) begin
            chk("setup_from_idle", 32'(prev_psel), 32'h0);
            if (apb_q.size() == 0) chk("unexpected_setup", 32'h1, 32'h0);
            else begin
               apb_t e;
               e = apb_q.pop_front();
               chk("paddr", paddr_o, e.addr);
               chk("pwrite", 32'(pwrite_o), 32'(e.we));
               if (e.we) chk("pwdata", pwdata_o, e.wdata);
               chk("psel_latency", cyc, e.cyc + 1);
            end
            cur_addr = paddr_o; cur_wdata = pwdata_o; cur_we = pwrite_o; m_acc = 0;
         end
         if (psel_o && penable_o) begin
            chk("access_follows_setup", 32'(prev_psel), 32'h1);
            chk("paddr_stable", paddr_o, cur_addr);
            chk("pwdata_stable", pwdata_o, cur_wdata);
            chk("pwrite_stable", 32'(pwrite_o), 32'(cur_we));
            m_acc++;
         end
         if (rvalid_o) begin
            chk("rvalid_pulse", 32'(prev_rvalid), 32'h0);
            chk("psel_low_at_rvalid", {30'h0, psel_o, penable_o}, 32'h0);
            if (rsp_q.size() == 0) chk("unexpected_rvalid", 32'h1, 32'h0);
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("rdata", rdata_o, r.rdata);
               chk("err", 32'(err_o), 32'(r.err));
               chk("access_cycles", m_acc, r.acc);
               chk("rvalid_latency", cyc, r.cyc + 2 + r.acc);
            end
         end
      end
      prev_psel   = psel_o;
      prev_rvalid = rvalid_o;
   end

   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd, input int ws,
                        input logic [31:0] pd, input logic se, input bit keep, input bit exp_rsp,
                        input bit chk_gap);
      int   n = 0;
      apb_t ea;
      rsp_t er;
      slv_t es;
      @(posedge clk); #1;
      req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd;
      do begin
         @(negedge clk); n++;
      end while (!gnt_o && n < 50);
      if (!gnt_o) chk("gnt_timeout", 32'h0, 32'h1);
      if (chk_gap) chk("gnt_spacing", cyc - last_gnt, 4);
      last_gnt = cyc;
      es.ws = ws; es.pd = pd; es.se = se;
      slv_q.push_back(es);
      ea.addr = a; ea.we = w; ea.wdata = wd; ea.cyc = cyc;
      apb_q.push_back(ea);
      if (exp_rsp) begin
         er = model(w, ws, pd, se);
         er.cyc = cyc;
         rsp_q.push_back(er);
      end
      if (!keep) begin
         @(posedge clk); #1;
         req_i = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((rsp_q.size() != 0 || psel_o) && n < 300) begin
         @(negedge clk); n++;
      end
      if (n >= 300) chk("drain_timeout", 32'h0, 32'h1);
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
      pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {paddr_o | pwdata_o | rdata_o},  32'h0);
      chk("reset_ctrl", {26'h0, pwrite_o, psel_o, penable_o, rvalid_o, err_o, gnt_o}, 32'h0);
      @(posedge clk); #1 rst_i = 1'b0;

      // directed: zero-wait read, waited write, slave error, timeout, pready on last cycle
      issue(32'h1A10_0004, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0, 0, 1, 0); drain();
      issue(32'h1A10_1000, 1'b1, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 1'b0, 0, 1, 0); drain();
      issue(32'h1A10_2008, 1'b0, 32'h0, 1, 32'hAAAA_5555, 1'b1, 0, 1, 0); drain();
      issue(32'h1A10_300C, 1'b0, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 0, 1, 0); drain();
      issue(32'h1A10_3010, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 0, 1, 0); drain();

      // reset mid-ACCESS aborts without a response
      issue(32'h1A10_4000, 1'b0, 32'h0, 5, 32'h1111_2222, 1'b0, 0, 0, 0);
      n = 0;
      while (!penable_o && n < 20) begin @(negedge clk); n++; end
      chk("reached_access", 32'(penable_o), 32'h1);
      @(posedge clk); #1 rst_i = 1'b1;
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_abort", {29'h0, psel_o, penable_o, rvalid_o}, 32'h0);
      repeat (3) @(negedge clk);
      issue(32'h1A10_4004, 1'b0, 32'h0, 0, 32'h3333_4444, 1'b0, 0, 1, 0); drain();

      // back-to-back reads with req held high
      issue(32'h0, 1'b0, 32'h0, 0, 32'h0000_00A0, 1'b0, 1, 1, 0);
      issue(32'h4, 1'b0, 32'h0, 0, 32'h0000_00A4, 1'b0, 1, 1, 1);
      issue(32'h8, 1'b0, 32'h0, 0, 32'h0000_00A8, 1'b0, 0, 1, 1);
      drain();

      // randomized traffic, wait states straddling the timeout
      for (int i = 0; i < 30; i++) begin
         issue({16'h1A10, 14'($urandom), 2'b00}, 1'($urandom), 32'($urandom),
               int'($urandom_range(0, TO + 2)), 32'($urandom), 1'($urandom), 0, 1, 0);
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();

      chk("scoreboard_empty", rsp_q.size() + apb_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
